// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple adder/subtractor; sub=1 computes a - b as a + ~b + 1.
module addsub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    logic [N-1:0] b_eff;
    logic [N:0]   c;
    logic         unused_carry;

    assign b_eff        = b ^ {N{sub}};
    assign c[0]         = sub;
    // Results are taken modulo 2^N; the final carry is intentionally dropped.
    assign unused_carry = c[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// unsigned or two's-complement operands, full 2*WIDTH product plus overflow flag.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand, mplier;
    logic               smode;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               bit_now, last, sub;
    logic [WIDTH:0]     addend, sum, hi_sh;
    logic [WIDTH-1:0]   lo_sh;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     top_bits;
    logic               ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Last signed step carries weight -2^(W-1), hence subtract.
    assign bit_now = mplier[cnt];
    assign last    = (cnt == CW'(WIDTH - 1));
    assign sub     = bit_now & smode & last;
    assign addend  = bit_now ? {smode & mcand[WIDTH-1], mcand} : '0;

    addsub_n #(.N(WIDTH + 1)) u_addsub (
        .a   (acc_hi),
        .b   (addend),
        .sub (sub),
        .s   (sum)
    );

    assign hi_sh    = {smode & sum[WIDTH], sum[WIDTH:1]};
    assign lo_sh    = {sum[0], acc_lo[WIDTH-1:1]};
    assign prod_d   = {hi_sh[WIDTH-1:0], lo_sh};
    assign top_bits = prod_d[2*WIDTH-1:WIDTH-1];
    assign ovf_d    = smode ? ~((&top_bits) | ~(|top_bits))
                            : (|prod_d[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            smode   <= 1'b0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    smode  <= signed_mode;
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= '0;
                end
                ST_RUN: begin
                    acc_hi <= hi_sh;
                    acc_lo <= lo_sh;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        product <= prod_d;
                        ovf     <= ovf_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, ovf;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Stimulus only: start at edge 0, scramble inputs afterwards, and report
    // the index of the edge closing the done cycle (0 = never seen).
    task automatic run_op(input logic sm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [2*W-1:0] p, output logic o,
                          output int done_edge, output bit held);
        logic [2*W-1:0] p0;
        p0 = product;
        @(negedge clk);
        start = 1'b1; signed_mode = sm; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; signed_mode = ~sm; a = ~ia; b = ib ^ 8'h5A;
        done_edge = 0; held = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (done) begin done_edge = k + 1; break; end
            if (product !== p0 || busy !== 1'b1) held = 1'b0;
            @(negedge clk);
        end
        p = product; o = ovf;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, ovf, product} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b product=%h, want all zero", busy, done, ovf, product);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [2*W-1:0] p; logic o; int de; bit held;
        run_op(1'b0, 8'd255, 8'd255, p, o, de, held);
        checks++;
        if (p !== 16'hFE01 || o !== 1'b1) begin
            errors++; $display("FAIL u255x255: product=%h ovf=%b, want fe01 1", p, o);
        end
        checks++;
        if (de !== 9) begin
            errors++; $display("FAIL u255x255_latency: done edge=%0d, want 9", de);
        end
        checks++;
        if (!held) begin
            errors++; $display("FAIL u255x255_busy_hold: busy dropped or product moved during RUN");
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 16'hFE01) begin
            errors++; $display("FAIL u255x255_after: done=%b busy=%b product=%h, want 0 0 fe01", done, busy, product);
        end
    endtask

    task automatic test_signed();
        logic [2*W-1:0] p; logic o; int de; bit held;
        run_op(1'b1, 8'hFD, 8'h05, p, o, de, held);
        checks++;
        if (p !== 16'hFFF1 || o !== 1'b0) begin
            errors++; $display("FAIL s_m3x5: product=%h ovf=%b, want fff1 0", p, o);
        end
        run_op(1'b1, 8'h80, 8'h80, p, o, de, held);
        checks++;
        if (p !== 16'h4000 || o !== 1'b1) begin
            errors++; $display("FAIL s_m128xm128: product=%h ovf=%b, want 4000 1", p, o);
        end
        checks++;
        if (!held) begin
            errors++; $display("FAIL s_hold: previous product not held during RUN");
        end
        run_op(1'b1, 8'h7F, 8'h02, p, o, de, held);
        checks++;
        if (p !== 16'h00FE || o !== 1'b1) begin
            errors++; $display("FAIL s_127x2: product=%h ovf=%b, want 00fe 1", p, o);
        end
    endtask

    task automatic test_edges();
        logic [2*W-1:0] p; logic o; int de; bit held;
        run_op(1'b0, 8'h00, 8'hAB, p, o, de, held);
        checks++;
        if (p !== 16'h0000 || o !== 1'b0) begin
            errors++; $display("FAIL u0xab: product=%h ovf=%b, want 0000 0", p, o);
        end
        run_op(1'b0, 8'd15, 8'd17, p, o, de, held);
        checks++;
        if (p !== 16'h00FF || o !== 1'b0) begin
            errors++; $display("FAIL u15x17: product=%h ovf=%b, want 00ff 0", p, o);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [2*W-1:0] pd = '0;
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 8'd12; b = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done) begin ndone++; pd = product; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || pd !== 16'h0078) begin
            errors++; $display("FAIL ignore_start: dones=%0d product=%h, want 1 0078", ndone, pd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ignore_start_queue: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        logic [2*W-1:0] p; logic o; int de; bit held;
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 8'd200; b = 8'd201;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || product !== 16'h0000 || done !== 1'b0) begin
            errors++; $display("FAIL abort_now: busy=%b product=%h done=%b, want 0 0000 0", busy, product, done);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0 || product !== 16'h0000) begin
            errors++; $display("FAIL abort_quiet: active cycles=%0d product=%h, want 0 0000", ndone, product);
        end
        run_op(1'b0, 8'd6, 8'd7, p, o, de, held);
        checks++;
        if (p !== 16'h002A || de !== 9) begin
            errors++; $display("FAIL after_reset: product=%h done edge=%0d, want 002a 9", p, de);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   va[4]  = '{8'd200, 8'h80, 8'h10, 8'h7F};
        logic [W-1:0]   vb[4]  = '{8'd3,   8'h01, 8'h10, 8'h7F};
        logic           vs[4]  = '{1'b0,   1'b1,  1'b0,  1'b1};
        logic [2*W-1:0] ep[4]  = '{16'h0258, 16'hFF80, 16'h0100, 16'h3F01};
        logic           eo[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        int n = 0, last_t = -1, t = 0;
        logic prev_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; a = va[0]; b = vb[0]; signed_mode = vs[0];
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk); t++;
            if (busy && !prev_busy) begin
                a = W'($urandom); b = W'($urandom); signed_mode = ~signed_mode;
            end
            prev_busy = busy;
            if (done) begin
                checks++;
                if (product !== ep[n] || ovf !== eo[n]) begin
                    errors++; $display("FAIL b2b_%0d: product=%h ovf=%b, want %h %b", n, product, ovf, ep[n], eo[n]);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t !== 10) begin
                        errors++; $display("FAIL b2b_period_%0d: %0d cycles, want 10", n, t - last_t);
                    end
                end
                last_t = t;
                n++;
                if (n < 4) begin a = va[n]; b = vb[n]; signed_mode = vs[n]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL b2b_count: %0d dones, want 4", n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_edges();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
